// File: rtl/flex_stp_deser.sv
// Multi-lane framed serial-to-parallel deserialiser with a valid/ready holding
// register and a sticky overrun flag for words lost before being consumed.
module flex_stp_deser #(
  parameter int unsigned NUM_BITS  = 8,
  parameter int unsigned NUM_LANES = 1,
  parameter bit          IDLE_BIT  = 1'b1
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          shift_enable,
  input  logic [NUM_LANES-1:0]          serial_in,
  input  logic                          shift_msb,
  input  logic                          clear,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [NUM_LANES*NUM_BITS-1:0] out_data,
  output logic [$clog2(NUM_BITS)-1:0]   bit_count,
  output logic                          overrun
);

  localparam int unsigned CNT_W  = $clog2(NUM_BITS);
  localparam int unsigned DATA_W = NUM_LANES * NUM_BITS;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] sreg_shifted;
  logic              complete_c;

  // Post-shift image of every lane; completion captures this, so the bit
  // entering on the final edge lands in the word.
  always_comb begin
    sreg_shifted = sreg;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (shift_msb) begin
        sreg_shifted[i*NUM_BITS +: NUM_BITS] =
          {sreg[i*NUM_BITS +: NUM_BITS-1], serial_in[i]};
      end else begin
        sreg_shifted[i*NUM_BITS +: NUM_BITS] =
          {serial_in[i], sreg[i*NUM_BITS+1 +: NUM_BITS-1]};
      end
    end
  end

  assign complete_c = shift_enable && (bit_count == LAST_BIT);

  // Shift, framing counter and holding register with handshake.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sreg      <= {DATA_W{IDLE_BIT}};
      out_data  <= {DATA_W{IDLE_BIT}};
      out_valid <= 1'b0;
      bit_count <= '0;
      overrun   <= 1'b0;
    end else if (clear) begin
      // out_data intentionally retained; only the partial word is discarded.
      sreg      <= {DATA_W{IDLE_BIT}};
      out_valid <= 1'b0;
      bit_count <= '0;
      overrun   <= 1'b0;
    end else begin
      if (shift_enable) begin
        sreg      <= sreg_shifted;
        bit_count <= complete_c ? '0 : bit_count + CNT_W'(1);
      end
      if (complete_c) begin
        out_data  <= sreg_shifted;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flex_stp_deser.sv
// Directed bench for flex_stp_deser: table of full words plus hand-written
// sequences for overrun, simultaneous accept, mid-word abort and streaming.
module tb_flex_stp_deser;

  localparam int unsigned NB = 8;
  localparam int unsigned NL = 2;

  logic          clk;
  logic          n_rst;
  logic          shift_enable;
  logic [NL-1:0] serial_in;
  logic          shift_msb;
  logic          clear;
  logic          out_ready;
  logic          out_valid;
  logic [15:0]   out_data;
  logic [2:0]    bit_count;
  logic          overrun;

  int errors = 0;
  int checks = 0;

  flex_stp_deser #(.NUM_BITS(NB), .NUM_LANES(NL), .IDLE_BIT(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable),
    .serial_in(serial_in), .shift_msb(shift_msb), .clear(clear),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .bit_count(bit_count), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          msb;
    bit          gap;
    logic [7:0]  l0;   // bit 7 is sent first
    logic [7:0]  l1;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends one word on both lanes; out_ready is held low except on the last bit.
  task automatic send_word(input bit msb, input bit gap, input logic [7:0] l0,
                           input logic [7:0] l1, input bit ready_last);
    for (int i = 0; i < 8; i++) begin
      shift_msb    = msb;
      shift_enable = 1'b1;
      serial_in    = {l1[7-i], l0[7-i]};
      out_ready    = (i == 7) ? ready_last : 1'b0;
      tick();
      if (gap && i != 7) begin
        shift_enable = 1'b0;
        serial_in    = ~serial_in;
        shift_msb    = ~msb;
        tick();
      end
    end
    shift_enable = 1'b0;
    out_ready    = 1'b0;
  endtask

  int         vcount;
  logic [7:0] first_w;
  logic [7:0] last_w;
  logic [7:0] w;

  initial begin
    vecs[0] = '{msb: 1'b1, gap: 1'b0, l0: 8'hB2, l1: 8'h00, exp: 16'h00B2};
    vecs[1] = '{msb: 1'b0, gap: 1'b0, l0: 8'hB2, l1: 8'h00, exp: 16'h004D};
    vecs[2] = '{msb: 1'b1, gap: 1'b0, l0: 8'h0F, l1: 8'hF0, exp: 16'hF00F};
    vecs[3] = '{msb: 1'b0, gap: 1'b1, l0: 8'h0F, l1: 8'hF0, exp: 16'h0FF0};
    vecs[4] = '{msb: 1'b1, gap: 1'b1, l0: 8'hA5, l1: 8'h3C, exp: 16'h3CA5};
    vecs[5] = '{msb: 1'b0, gap: 1'b0, l0: 8'h01, l1: 8'h80, exp: 16'h0180};

    n_rst = 1'b0; shift_enable = 1'b0; serial_in = '0; shift_msb = 1'b1;
    clear = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("reset_data", 32'(out_data), 32'h0000FFFF);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_count", 32'(bit_count), 32'd0);
    n_rst = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v].msb, vecs[v].gap, vecs[v].l0, vecs[v].l1, 1'b0);
      check($sformatf("vec%0d_valid", v), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_data", v), 32'(out_data), 32'(vecs[v].exp));
      check($sformatf("vec%0d_count", v), 32'(bit_count), 32'd0);
      check($sformatf("vec%0d_overrun", v), 32'(overrun), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("vec%0d_accept", v), 32'(out_valid), 32'd0);
    end

    // Overrun: two words without consumption, then clear.
    send_word(1'b1, 1'b0, 8'hB2, 8'h00, 1'b0);
    check("ovr_first_overrun", 32'(overrun), 32'd0);
    send_word(1'b1, 1'b0, 8'h0F, 8'h00, 1'b0);
    check("ovr_valid", 32'(out_valid), 32'd1);
    check("ovr_lane0", 32'(out_data[7:0]), 32'h0F);
    check("ovr_flag", 32'(overrun), 32'd1);
    tick();
    check("ovr_sticky", 32'(overrun), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_overrun", 32'(overrun), 32'd0);
    check("clr_valid", 32'(out_valid), 32'd0);
    check("clr_data_kept", 32'(out_data[7:0]), 32'h0F);

    // Completion on the same edge as an accept of the previous word.
    send_word(1'b1, 1'b0, 8'h3C, 8'h11, 1'b0);
    check("sim_a_valid", 32'(out_valid), 32'd1);
    send_word(1'b1, 1'b0, 8'h5A, 8'h22, 1'b1);
    check("sim_valid", 32'(out_valid), 32'd1);
    check("sim_data", 32'(out_data), 32'h0000225A);
    check("sim_overrun", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("sim_drained", 32'(out_valid), 32'd0);

    // Mid-word abort.
    shift_msb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      shift_enable = 1'b1;
      serial_in = 2'b11;
      tick();
    end
    shift_enable = 1'b0;
    check("abort_count5", 32'(bit_count), 32'd5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_count0", 32'(bit_count), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    w = 8'hA5;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      shift_enable = 1'b1;
      serial_in = {1'b0, w[7-i]};
      tick();
      if (out_valid) vcount++;
    end
    shift_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!out_valid) vcount = vcount + 100;
    end
    check("abort_one_word", 32'(vcount), 32'd1);
    check("abort_data", 32'(out_data[7:0]), 32'hA5);
    check("abort_overrun", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    tick();

    // Streaming: enable and ready held high for two words.
    vcount = 0;
    first_w = '0;
    last_w = '0;
    for (int k = 0; k < 16; k++) begin
      w = (k < 8) ? 8'hC3 : 8'h7E;
      shift_enable = 1'b1;
      serial_in = {1'b0, w[7-(k%8)]};
      tick();
      if (out_valid) begin
        if (vcount == 0) first_w = out_data[7:0];
        last_w = out_data[7:0];
        vcount++;
      end
    end
    shift_enable = 1'b0;
    tick();
    check("stream_words", 32'(vcount), 32'd2);
    check("stream_first", 32'(first_w), 32'hC3);
    check("stream_second", 32'(last_w), 32'h7E);
    check("stream_drained", 32'(out_valid), 32'd0);
    check("stream_overrun", 32'(overrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flex_stp_deser.md
# flex_stp_deser

Parametrised multi-lane serial-to-parallel deserialiser: the framed successor to the plain flex serial-to-parallel shift register. Each of NUM_LANES lanes shifts one bit per enabled cycle. A shared bit counter frames NUM_BITS-bit words, and each completed word is transferred into an output holding register. That register is presented downstream with a valid/ready handshake, and a sticky overrun flag reports lost words. Shift direction is selectable at run time. The block sits between a bit-rate receive front end and word-oriented consumers such as a FIFO or decoder.

## Interface
- NUM_BITS, 8, bits per word per lane; must be ≥ 2
- NUM_LANES, 1, number of parallel serial lanes sharing one counter and handshake
- IDLE_BIT, 1, fill value of the shift registers at reset and on clear (idle-line level)
- clk  input  1  sole clock, all state updates on rising edge
- n_rst  input  1  reset, synchronous and active-low
- shift_enable  input  1  when high, every lane shifts in one bit this edge
- serial_in  input  NUM_LANES  one bit per lane; bit i feeds lane i
- shift_msb  input  1  1: shift toward MSB, new bit enters bit 0; 0: shift toward LSB, new bit enters bit NUM_BITS-1
- clear  input  1  synchronous abort of the partial word
- out_ready  input  1  consumer accepts out_data when out_valid is also high
- out_valid  output  1  holding register contains an unconsumed word
- out_data  output  NUM_LANES*NUM_BITS  lane i word at [i*NUM_BITS +: NUM_BITS]
- bit_count  output  $clog2(NUM_BITS)  bits already shifted into the current word (0..NUM_BITS-1)
- overrun  output  1  sticky: a completed word replaced an unconsumed one

## Operation
- Reset (n_rst low at an edge) sets the following:
  - every shift register bit to IDLE_BIT
  - out_data to all IDLE_BIT
  - out_valid = 0, bit_count = 0, overrun = 0
- Reset overrides all other inputs.
- Priority: reset > clear > shift/handshake.
- clear sets the following:
  - shift registers to IDLE_BIT and bit_count = 0
  - out_valid = 0 and overrun = 0
  - out_data is left unchanged
- An edge with shift_enable high applies the shift to every lane, using shift_msb as sampled on that edge.
  - Changing shift_msb mid-word is legal: each bit follows the direction in force when it shifted.
- Counter behaviour on an edge with shift_enable high:
  - If bit_count < NUM_BITS-1, bit_count increments.
  - If bit_count = NUM_BITS-1, the word is complete and bit_count wraps to 0.
- On completion, the post-shift register contents (including the bit entering this edge) are loaded into out_data.
- When shift_enable is low, the shift registers and bit_count hold.
- Holding register and handshake:
  - An accept occurs when out_valid and out_ready are both high at an edge; with no completion on that edge, out_valid clears.
  - Completion with out_valid = 0 loads out_data and sets out_valid = 1.
  - Completion with out_valid = 1 and out_ready = 1 (simultaneous accept) loads the new word, keeps out_valid = 1, and leaves overrun unchanged.
  - Completion with out_valid = 1 and out_ready = 0 overwrites out_data with the new word, keeps out_valid = 1, and sets overrun.
- overrun clears only on reset or clear.
- out_ready is ignored while out_valid = 0.
- The shift registers themselves are internal; only the framed word is visible.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Word latency: out_valid rises on the edge that samples the NUM_BITS-th shift_enable of a word. It is visible in the following cycle.
- Back-to-back words with shift_enable held high and out_ready held high yield one out_valid cycle every NUM_BITS cycles, with no lost bits.
- Gaps in shift_enable stretch a word arbitrarily; bits are never lost or duplicated.
- Reset or clear asserted mid-word discards the partial word. The next word starts counting from the first following shift_enable.

## Test plan
- Basic word, MSB-first: NUM_BITS=8, NUM_LANES=2, shift_msb=1. Lane0 receives 1,0,1,1,0,0,1,0 and lane1 receives all 0 on 8 consecutive shift_enable cycles.
  - Required: out_valid=1 the cycle after the 8th shift, out_data=16'h00B2, bit_count=0.
- Basic word, LSB-first: same stimulus with shift_msb=0.
  - Required: out_data=16'h004D.
- Reset values: hold n_rst low for 2 edges.
  - Required: out_data=16'hFFFF (IDLE_BIT=1), out_valid=0, overrun=0, bit_count=0.
- Overrun: out_ready=0, then two full words 8'hB2 then 8'h0F on lane0.
  - Required after word 2: out_valid=1, lane0 of out_data=8'h0F, overrun=1.
  - Then assert clear for one cycle. Required: overrun=0, out_valid=0.
- Simultaneous accept and completion: out_valid=1 with word A, and out_ready=1 on the same edge as word B's 8th shift.
  - Required: out_valid stays 1, out_data=B, overrun=0.
- Mid-word abort: shift 5 bits (bit_count=5), assert clear, then shift 8 bits of 8'hA5 on lane0 with shift_msb=1.
  - Required: bit_count=0 after the clear, and exactly one word with lane0=8'hA5.
